// File: rtl/branch_unit_bht_if.sv
// Fetch/execute-side bundle of the branch unit: fetch lookup, execute resolve and statistics.
// Latency: carries combinational and registered signals alike; the interface itself has none.
// Backpressure: none; every signal is sampled or driven every cycle.
// Ports (master = pipeline side, slave = branch unit):
//   f_pc -> f_pred_taken                  fetch prediction lookup
//   x_valid/x_opcode/x_funct3/x_pc/
//   x_rs1/x_rs2/x_pred_taken/x_jump ->    execute resolve inputs
//   x_branch_taken/x_redir_target/
//   x_redir_fall/x_pc_select/x_mispredict  execute resolve outputs
//   stat_branches/stat_mispred            saturating statistics
interface branch_unit_bht_if #(
  parameter int XLEN   = 32,
  parameter int STAT_W = 32
);
  logic [XLEN-1:0]   f_pc;
  logic              f_pred_taken;
  logic              x_valid;
  logic [6:0]        x_opcode;
  logic [2:0]        x_funct3;
  logic [XLEN-1:0]   x_pc;
  logic [XLEN-1:0]   x_rs1;
  logic [XLEN-1:0]   x_rs2;
  logic              x_pred_taken;
  logic              x_jump;
  logic              x_branch_taken;
  logic              x_redir_target;
  logic              x_redir_fall;
  logic              x_pc_select;
  logic              x_mispredict;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispred;

  modport master (
    output f_pc, x_valid, x_opcode, x_funct3, x_pc, x_rs1, x_rs2, x_pred_taken, x_jump,
    input  f_pred_taken, x_branch_taken, x_redir_target, x_redir_fall, x_pc_select,
           x_mispredict, stat_branches, stat_mispred
  );

  modport slave (
    input  f_pc, x_valid, x_opcode, x_funct3, x_pc, x_rs1, x_rs2, x_pred_taken, x_jump,
    output f_pred_taken, x_branch_taken, x_redir_target, x_redir_fall, x_pc_select,
           x_mispredict, stat_branches, stat_mispred
  );
endinterface

// File: rtl/branch_unit_bht.sv
// Bimodal BHT (2-bit saturating counters) plus execute-stage RV32 branch resolver and stats.
// Latency: prediction and all resolve outputs are combinational; training and stats update on the clock edge.
// Backpressure: none; a valid branch is resolved and trained in the cycle it is presented.
// Ports:
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus (slave)  fetch lookup, execute resolve, statistics (see branch_unit_bht_if)
module branch_unit_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter int         INDEX_LSB   = 2,
  parameter logic [1:0] CNT_INIT    = 2'b01,
  parameter int         STAT_W      = 32
) (
  input logic              clk,
  input logic              reset,
  branch_unit_bht_if.slave bus
);
  localparam int                IDX_W    = $clog2(BHT_ENTRIES);
  localparam logic [6:0]        OP_BRANCH = 7'b1100011;
  localparam logic [STAT_W-1:0] STAT_ONE = 1;

  logic [1:0]        cnt_q [BHT_ENTRIES];
  logic [1:0]        cnt_cur;
  logic [1:0]        cnt_d;
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  x_idx;
  logic              is_br;
  logic              cond;
  logic [STAT_W-1:0] stat_br_q, stat_br_d;
  logic [STAT_W-1:0] stat_mp_q, stat_mp_d;
  logic              unused_pc_bits;

  // Only the index field of each PC matters; the rest aliases.
  assign unused_pc_bits = ^{bus.f_pc, bus.x_pc};

  always_comb begin
    f_idx = bus.f_pc[INDEX_LSB +: IDX_W];
    x_idx = bus.x_pc[INDEX_LSB +: IDX_W];
    is_br = bus.x_valid && (bus.x_opcode == OP_BRANCH) &&
            (bus.x_funct3 != 3'b010) && (bus.x_funct3 != 3'b011);
    cond  = 1'b0;
    case (bus.x_funct3)
      3'b000:  cond = (bus.x_rs1 == bus.x_rs2);
      3'b001:  cond = (bus.x_rs1 != bus.x_rs2);
      3'b100:  cond = ($signed(bus.x_rs1) <  $signed(bus.x_rs2));
      3'b101:  cond = ($signed(bus.x_rs1) >= $signed(bus.x_rs2));
      3'b110:  cond = (bus.x_rs1 <  bus.x_rs2);
      3'b111:  cond = (bus.x_rs1 >= bus.x_rs2);
      default: cond = 1'b0;
    endcase
  end

  // Prediction reads the stored value; a same-index training write lands only at the edge.
  assign bus.f_pred_taken   = cnt_q[f_idx][1];
  assign bus.x_branch_taken = is_br && cond;
  assign bus.x_mispredict   = is_br && (cond != bus.x_pred_taken);
  assign bus.x_redir_target = (bus.x_valid && bus.x_jump) || (is_br && cond && !bus.x_pred_taken);
  assign bus.x_redir_fall   = is_br && !cond && bus.x_pred_taken && !bus.x_jump;
  assign bus.x_pc_select    = bus.x_redir_target || bus.x_redir_fall;
  assign bus.stat_branches  = stat_br_q;
  assign bus.stat_mispred   = stat_mp_q;

  always_comb begin
    cnt_cur = cnt_q[x_idx];
    if (cond) cnt_d = (cnt_cur == 2'b11) ? cnt_cur : cnt_cur + 2'd1;
    else      cnt_d = (cnt_cur == 2'b00) ? cnt_cur : cnt_cur - 2'd1;
    stat_br_d = (is_br && (stat_br_q != '1)) ? stat_br_q + STAT_ONE : stat_br_q;
    stat_mp_d = (bus.x_mispredict && (stat_mp_q != '1)) ? stat_mp_q + STAT_ONE : stat_mp_q;
  end

  // Reset wins over a pending training write in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < BHT_ENTRIES; i++) cnt_q[i] <= CNT_INIT;
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (is_br) cnt_q[x_idx] <= cnt_d;
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end
endmodule

// File: tb/tb_branch_unit_bht.sv
module tb_branch_unit_bht;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_unit_bht_if #(.XLEN(32), .STAT_W(32)) bus_a ();
  branch_unit_bht_if #(.XLEN(32), .STAT_W(4))  bus_b ();

  branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(64), .INDEX_LSB(2), .CNT_INIT(2'b01), .STAT_W(32))
    u_dut (.clk(clk), .reset(reset), .bus(bus_a.slave));
  branch_unit_bht #(.XLEN(32), .BHT_ENTRIES(64), .INDEX_LSB(2), .CNT_INIT(2'b01), .STAT_W(4))
    u_dut4 (.clk(clk), .reset(reset), .bus(bus_b.slave));

  typedef struct {
    bit          rst;
    logic [31:0] fpc, xpc, rs1, rs2;
    bit          v;
    logic [6:0]  op;
    logic [2:0]  f3;
    bit          pred, jump;
  } stim_t;

  typedef struct {
    logic        taken, rt, rf, sel, mis, fpred;
    logic [31:0] sb, sm;
    logic [3:0]  sb4, sm4;
  } exp_t;

  exp_t   exp_q[$];
  int     n_chk = 0;
  int     n_fail = 0;
  int     cnt[64];
  longint nb, nm;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: counters as plain integers 0..3, stats as unbounded counts clipped on read.
  function automatic int idx(input logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit cond_of(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return $signed(a) <  $signed(b);
      3'd5: return $signed(a) >= $signed(b);
      3'd6: return a <  b;
      3'd7: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) cnt[i] = 1;
    nb = 0;
    nm = 0;
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.fpc = 0; s.xpc = 0; s.rs1 = 0; s.rs2 = 0;
    s.v = 0; s.op = 0; s.f3 = 0; s.pred = 0; s.jump = 0;
    return s;
  endfunction

  function automatic stim_t br(input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b, input bit pred);
    stim_t s = idle();
    s.v = 1; s.op = 7'h63; s.f3 = f3; s.xpc = pc; s.fpc = pc;
    s.rs1 = a; s.rs2 = b; s.pred = pred;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst;
    bus_a.f_pc = s.fpc; bus_a.x_valid = s.v; bus_a.x_opcode = s.op; bus_a.x_funct3 = s.f3;
    bus_a.x_pc = s.xpc; bus_a.x_rs1 = s.rs1; bus_a.x_rs2 = s.rs2;
    bus_a.x_pred_taken = s.pred; bus_a.x_jump = s.jump;
    bus_b.f_pc = s.fpc; bus_b.x_valid = s.v; bus_b.x_opcode = s.op; bus_b.x_funct3 = s.f3;
    bus_b.x_pc = s.xpc; bus_b.x_rs1 = s.rs1; bus_b.x_rs2 = s.rs2;
    bus_b.x_pred_taken = s.pred; bus_b.x_jump = s.jump;
  endtask

  // Drive one cycle, queue its expected response, then advance the model past the edge.
  task automatic apply(input stim_t s);
    exp_t e;
    bit   c, isb;
    drive(s);
    c   = cond_of(s.f3, s.rs1, s.rs2);
    isb = s.v && (s.op == 7'h63) && (s.f3 != 3'd2) && (s.f3 != 3'd3);
    e.taken = isb && c;
    e.mis   = isb && (c != s.pred);
    e.rt    = (s.v && s.jump) || (isb && c && !s.pred);
    e.rf    = isb && !c && s.pred && !s.jump;
    e.sel   = e.rt || e.rf;
    e.fpred = cnt[idx(s.fpc)] >= 2;
    e.sb    = (nb > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : nb[31:0];
    e.sm    = (nm > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : nm[31:0];
    e.sb4   = (nb > 15) ? 4'hF : nb[3:0];
    e.sm4   = (nm > 15) ? 4'hF : nm[3:0];
    exp_q.push_back(e);
    if (s.rst) model_reset();
    else if (isb) begin
      if (c) cnt[idx(s.xpc)] = (cnt[idx(s.xpc)] == 3) ? 3 : cnt[idx(s.xpc)] + 1;
      else   cnt[idx(s.xpc)] = (cnt[idx(s.xpc)] == 0) ? 0 : cnt[idx(s.xpc)] - 1;
      nb++;
      if (e.mis) nm++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a full response every cycle; compare it mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_taken",  bus_a.x_branch_taken, e.taken);
        chk("mon_rtgt",   bus_a.x_redir_target, e.rt);
        chk("mon_rfall",  bus_a.x_redir_fall,   e.rf);
        chk("mon_pcsel",  bus_a.x_pc_select,    e.sel);
        chk("mon_mis",    bus_a.x_mispredict,   e.mis);
        chk("mon_fpred",  bus_a.f_pred_taken,   e.fpred);
        chk("mon_fpred4", bus_b.f_pred_taken,   e.fpred);
        chk("mon_sb",     bus_a.stat_branches,  e.sb);
        chk("mon_sm",     bus_a.stat_mispred,   e.sm);
        chk("mon_sb4",    bus_b.stat_branches,  e.sb4);
        chk("mon_sm4",    bus_b.stat_mispred,   e.sm4);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1;
    drive(s);
    step();
    model_reset();

    // Reset state
    s = idle(); s.fpc = 32'h1234_5678;
    apply(s); #1;
    chk("reset_fpred", bus_a.f_pred_taken, 0);
    chk("reset_sb", bus_a.stat_branches, 0);
    chk("reset_sm", bus_a.stat_mispred, 0);
    step();

    // Signed vs unsigned compares
    apply(br(3'b100, 32'h100, 32'hFFFF_FFFF, 32'h1, 0)); #1;
    chk("blt_neg", bus_a.x_branch_taken, 1);
    step();
    apply(br(3'b110, 32'h100, 32'hFFFF_FFFF, 32'h1, 0)); #1;
    chk("bltu_big", bus_a.x_branch_taken, 0);
    step();
    apply(br(3'b111, 32'h100, 32'hFFFF_FFFF, 32'h1, 0)); #1;
    chk("bgeu_big", bus_a.x_branch_taken, 1);
    step();

    // BEQ at 0x40 trained up, then a not-taken with a taken prediction
    apply(br(3'b000, 32'h40, 5, 5, 0)); #1;
    chk("beq_c1_rtgt", bus_a.x_redir_target, 1);
    chk("beq_c1_mis", bus_a.x_mispredict, 1);
    step();
    apply(br(3'b000, 32'h40, 7, 7, 0)); #1;
    chk("beq_c2_fpred", bus_a.f_pred_taken, 1);
    step();
    apply(br(3'b000, 32'h40, 9, 9, 0));
    step();
    apply(br(3'b000, 32'h40, 1, 2, 1)); #1;
    chk("beq_nt_rfall", bus_a.x_redir_fall, 1);
    step();
    s = idle(); s.fpc = 32'h40;
    apply(s); #1;
    chk("beq_after_fpred", bus_a.f_pred_taken, 1);
    step();

    // Same-index read/write: old value this cycle, trained value next
    apply(br(3'b000, 32'h80, 3, 3, 0)); #1;
    chk("coll_same_cycle", bus_a.f_pred_taken, 0);
    step();
    s = idle(); s.fpc = 32'h80;
    apply(s); #1;
    chk("coll_next_cycle", bus_a.f_pred_taken, 1);
    step();

    // Reserved funct3 and a jump
    apply(br(3'b010, 32'h84, 0, 0, 0)); #1;
    chk("f3_010_pcsel", bus_a.x_pc_select, 0);
    chk("f3_010_mis", bus_a.x_mispredict, 0);
    step();
    s = idle(); s.v = 1; s.op = 7'h6F; s.jump = 1; s.xpc = 32'h88;
    apply(s); #1;
    chk("jal_rtgt", bus_a.x_redir_target, 1);
    step();

    // Reset with a taken branch pending at 0xC0
    s = br(3'b000, 32'hC0, 1, 1, 0); s.rst = 1;
    apply(s);
    step();
    s = idle(); s.fpc = 32'hC0;
    apply(s); #1;
    chk("rst_train_dropped", bus_a.f_pred_taken, 0);
    chk("rst_sb_zero", bus_a.stat_branches, 0);
    step();

    // 17 mispredicted branches: 4-bit stats saturate
    for (int i = 0; i < 17; i++) begin
      apply(br(3'b000, 32'(i) << 2, 9, 9, 0));
      step();
    end
    s = idle();
    apply(s); #1;
    chk("sat_sb4", bus_b.stat_branches, 4'hF);
    chk("sat_sm4", bus_b.stat_mispred, 4'hF);
    chk("sat_sb32", bus_a.stat_branches, 17);
    step();

    // Randomized traffic with heavy index collisions
    for (int n = 0; n < 500; n++) begin
      s.rst  = ($urandom_range(0, 99) == 0);
      s.v    = ($urandom_range(0, 9) != 0);
      s.op   = ($urandom_range(0, 3) != 0) ? 7'h63 : 7'($urandom);
      s.f3   = 3'($urandom);
      s.xpc  = $urandom_range(0, 1) ? $urandom : (32'($urandom_range(0, 15)) << 2);
      s.fpc  = $urandom_range(0, 1) ? s.xpc : $urandom;
      s.rs1  = $urandom;
      case ($urandom_range(0, 3))
        0:       s.rs2 = s.rs1;
        1:       s.rs2 = s.rs1 ^ 32'h8000_0000;
        default: s.rs2 = $urandom;
      endcase
      s.pred = $urandom_range(0, 1) ? (cnt[idx(s.xpc)] >= 2) : 1'($urandom);
      s.jump = ($urandom_range(0, 9) == 0);
      apply(s);
      step();
    end

    @(negedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
